i2s_tdm_bram_streamer: RTL and testbench



---
 rtl/i2s_tdm_bram_streamer_if.sv | 19 +
 rtl/i2s_tdm_bram_streamer.sv | 175 +++++++++++++++++
 tb/tb_i2s_tdm_bram_streamer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_tdm_bram_streamer_if.sv
// rtl/i2s_tdm_bram_streamer_if.sv - BRAM read-port bundle between streamer and block RAM
interface i2s_tdm_bram_streamer_if;
    logic [31:0] BRAM_addr;
    logic        BRAM_clk;
    logic [31:0] BRAM_din;
    logic [31:0] BRAM_dout;
    logic        BRAM_en;
    logic        BRAM_rst;
    logic [3:0]  BRAM_we;

    modport master (
        output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we,
        input  BRAM_dout
    );
    modport slave (
        input  BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we,
        output BRAM_dout
    );
endinterface

// File: rtl/i2s_tdm_bram_streamer.sv
// rtl/i2s_tdm_bram_streamer.sv - streams a BRAM ring buffer out as I2S or TDM audio
module i2s_tdm_bram_streamer #(
    parameter int SAMPLE_W    = 24,
    parameter int NUM_CH      = 2,
    parameter int DEPTH_WORDS = 1024,
    parameter int BCLK_DIV    = 4,
    parameter int MCLK_DIV    = 2,
    parameter int MODE        = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           enable,
    input  logic                           mute,
    i2s_tdm_bram_streamer_if.master        bram,
    output logic                           audio_I2S_bclk,
    output logic                           audio_I2S_pblrc,
    output logic                           audio_I2S_pbdat,
    output logic                           mclk,
    output logic                           half_irq,
    output logic [$clog2(DEPTH_WORDS)-1:0] rd_ptr
);
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int FB_W   = $clog2(NUM_CH * 32);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam int MDIV_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
    state_t state, state_nx;

    logic [CH_W-1:0]     fetch_idx, cap_idx;
    logic                cap_valid;
    logic [SAMPLE_W-1:0] shadow [NUM_CH];
    logic [SAMPLE_W-1:0] bank   [NUM_CH];
    logic                running;
    logic [DIV_W-1:0]    div_cnt;
    logic [FB_W-1:0]     frame_bit, nb;
    logic                mute_q;
    logic [MDIV_W-1:0]   mclk_cnt;
    logic                rd_issue, fall_evt, frame_start, stop_evt, discard;
    logic [AW-1:0]       rd_ptr_inc;
    logic [SAMPLE_W-1:0] sh;
    logic                nxt_dat, nxt_lr;
    int                  pos;
    logic                unused_bits;

    assign bram.BRAM_clk  = clk;
    assign bram.BRAM_we   = 4'd0;
    assign bram.BRAM_din  = 32'd0;
    assign bram.BRAM_rst  = ~rstn;
    assign bram.BRAM_en   = rd_issue;
    assign bram.BRAM_addr = {{(30 - AW){1'b0}}, rd_ptr, 2'b00};
    assign unused_bits    = ^(bram.BRAM_dout >> SAMPLE_W);

    assign rd_ptr_inc  = rd_ptr + AW'(1);
    // frame_bit width is exact, so +1 wraps at the frame boundary
    assign nb          = frame_bit + FB_W'(1);
    assign fall_evt    = running && audio_I2S_bclk && (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign frame_start = enable && (state == FULL) && (!running || (fall_evt && nb == '0));
    assign stop_evt    = fall_evt && (nb == '0) && !frame_start;
    assign discard     = (state == FULL) && (stop_evt || (!running && !enable));

    always_comb begin
        state_nx = state;
        rd_issue = 1'b0;
        case (state)
            IDLE: if (enable) state_nx = REQ;
            REQ: begin
                rd_issue = 1'b1;
                if (fetch_idx == CH_W'(NUM_CH - 1)) state_nx = WAIT;
            end
            WAIT: state_nx = FULL;
            FULL: begin
                if (frame_start)  state_nx = REQ;
                else if (discard) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            fetch_idx <= '0;
            cap_idx   <= '0;
            cap_valid <= 1'b0;
            rd_ptr    <= '0;
            half_irq  <= 1'b0;
        end else begin
            state     <= state_nx;
            cap_valid <= rd_issue;
            cap_idx   <= fetch_idx;
            half_irq  <= 1'b0;
            if (rd_issue) begin
                fetch_idx <= fetch_idx + CH_W'(1);
                rd_ptr    <= rd_ptr_inc;
                half_irq  <= (rd_ptr_inc == '0) || (rd_ptr_inc == AW'(DEPTH_WORDS / 2));
            end else if (discard) begin
                // prefetched frame never played: rewind so restart resumes at it
                rd_ptr <= rd_ptr - AW'(NUM_CH);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else if (cap_valid) begin
            shadow[cap_idx] <= bram.BRAM_dout[SAMPLE_W-1:0];
        end
    end

    // bit 0 of every slot is a zero gap; sample MSB follows one BCLK later
    always_comb begin
        pos     = 32'(nb[4:0]);
        sh      = bank[nb[FB_W-1:5]] >> (SAMPLE_W - pos);
        nxt_dat = 1'b0;
        if (!mute_q && pos != 0 && pos <= SAMPLE_W) nxt_dat = sh[0];
        nxt_lr  = (MODE == 0) ? nb[5] : (nb == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running         <= 1'b0;
            div_cnt         <= '0;
            frame_bit       <= '0;
            audio_I2S_bclk  <= 1'b0;
            audio_I2S_pblrc <= 1'b0;
            audio_I2S_pbdat <= 1'b0;
            mute_q          <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
        end else if (frame_start) begin
            running         <= 1'b1;
            div_cnt         <= '0;
            frame_bit       <= '0;
            audio_I2S_bclk  <= 1'b0;
            audio_I2S_pblrc <= (MODE != 0);
            audio_I2S_pbdat <= 1'b0;
            mute_q          <= mute;
            bank            <= shadow;
        end else if (stop_evt) begin
            running         <= 1'b0;
            div_cnt         <= '0;
            frame_bit       <= '0;
            audio_I2S_bclk  <= 1'b0;
            audio_I2S_pblrc <= 1'b0;
            audio_I2S_pbdat <= 1'b0;
        end else if (running) begin
            if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
                div_cnt        <= '0;
                audio_I2S_bclk <= ~audio_I2S_bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_evt) begin
                frame_bit       <= nb;
                audio_I2S_pblrc <= nxt_lr;
                audio_I2S_pbdat <= nxt_dat;
                if (nb[4:0] == 5'd0) mute_q <= mute;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mclk_cnt <= '0;
            mclk     <= 1'b0;
        end else if (mclk_cnt == MDIV_W'(MCLK_DIV - 1)) begin
            mclk_cnt <= '0;
            mclk     <= ~mclk;
        end else begin
            mclk_cnt <= mclk_cnt + MDIV_W'(1);
        end
    end
endmodule

// File: tb/tb_i2s_tdm_bram_streamer.sv
// tb/tb_i2s_tdm_bram_streamer.sv - directed bench: I2S ring wrap/mute/stop/reset and TDM framing
module tb_i2s_tdm_bram_streamer;
    logic clk = 1'b0;
    logic rstn, enable0, enable1, mute0, mute1;
    logic bclk0, pblrc0, pbdat0, mclk0, half0;
    logic bclk1, pblrc1, pbdat1, mclk1, half1;
    logic [2:0] rd_ptr0;
    logic [3:0] rd_ptr1;
    logic [31:0] mem0 [8];
    logic [31:0] mem1 [16];
    int n_cmp = 0, n_err = 0;
    int addr_log [64];
    int irq_log [16];
    int addr_cnt = 0, irq_cnt = 0, en_dis0 = 0, en_dis1 = 0;

    always #5 clk = ~clk;

    i2s_tdm_bram_streamer_if bif0 ();
    i2s_tdm_bram_streamer_if bif1 ();

    i2s_tdm_bram_streamer #(.DEPTH_WORDS(8)) dut0 (
        .clk(clk), .rstn(rstn), .enable(enable0), .mute(mute0), .bram(bif0),
        .audio_I2S_bclk(bclk0), .audio_I2S_pblrc(pblrc0), .audio_I2S_pbdat(pbdat0),
        .mclk(mclk0), .half_irq(half0), .rd_ptr(rd_ptr0)
    );

    i2s_tdm_bram_streamer #(.SAMPLE_W(16), .NUM_CH(4), .DEPTH_WORDS(16), .MODE(1)) dut1 (
        .clk(clk), .rstn(rstn), .enable(enable1), .mute(mute1), .bram(bif1),
        .audio_I2S_bclk(bclk1), .audio_I2S_pblrc(pblrc1), .audio_I2S_pbdat(pbdat1),
        .mclk(mclk1), .half_irq(half1), .rd_ptr(rd_ptr1)
    );

    always @(posedge clk) begin
        if (bif0.BRAM_en) bif0.BRAM_dout <= mem0[bif0.BRAM_addr[4:2]];
        if (bif1.BRAM_en) bif1.BRAM_dout <= mem1[bif1.BRAM_addr[5:2]];
    end

    always @(negedge clk) begin
        if (bif0.BRAM_en && addr_cnt < 64) begin
            addr_log[addr_cnt] = int'(bif0.BRAM_addr);
            addr_cnt++;
        end
        if (half0 && irq_cnt < 16) begin
            irq_log[irq_cnt] = int'(rd_ptr0);
            irq_cnt++;
        end
        if (!enable0 && bif0.BRAM_en) en_dis0++;
        if (!enable1 && bif1.BRAM_en) en_dis1++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] i2s_exp(input logic [23:0] a, input logic [23:0] b);
        return {1'b0, a, 7'd0, 1'b0, b, 7'd0};
    endfunction

    function automatic logic [127:0] tdm_exp(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] e);
        return {1'b0, a, 15'd0, 1'b0, b, 15'd0, 1'b0, c, 15'd0, 1'b0, e, 15'd0};
    endfunction

    // collects pbdat/pblrc on nbits BCLK rising edges, sampled at the clk falling edge
    task automatic cap(input int which, input int nbits, output logic [127:0] d,
                       output logic [127:0] lr, output int lat, output int per);
        int got = 0, n = 0, last = 0;
        logic b, bprev;
        d = '0; lr = '0; lat = -1; per = -1;
        bprev = (which == 0) ? bclk0 : bclk1;
        while (got < nbits && n < 4000) begin
            @(negedge clk);
            n++;
            b = (which == 0) ? bclk0 : bclk1;
            if (b && !bprev) begin
                if (lat < 0) lat = n;
                else if (per < 0) per = n - last;
                last = n;
                d  = {d[126:0], (which == 0) ? pbdat0 : pbdat1};
                lr = {lr[126:0], (which == 0) ? pblrc0 : pblrc1};
                got++;
            end
            bprev = b;
        end
        chk("cap_bits", 128'(got), 128'(nbits));
    endtask

    initial begin
        logic [127:0] d, lr, d1, lr1;
        int lat, per, tog, rises;
        logic prev;

        mem0[0] = 32'h00ABCDEF; mem0[1] = 32'h00123456; mem0[2] = 32'h00FFFFFF; mem0[3] = 32'h00000001;
        mem0[4] = 32'hFF800001; mem0[5] = 32'h00000002; mem0[6] = 32'h00F0F0F0; mem0[7] = 32'h000F0F0F;
        for (int i = 0; i < 16; i++) mem1[i] = 32'h0;
        mem1[0] = 32'h1111AAAA; mem1[1] = 32'h2222BBBB; mem1[2] = 32'h3333C3C5; mem1[3] = 32'h44448001;
        mem1[4] = 32'h55551234; mem1[5] = 32'h66665678; mem1[6] = 32'h77779ABC; mem1[7] = 32'h8888DEF0;
        bif0.BRAM_dout = '0; bif1.BRAM_dout = '0;
        rstn = 1'b0; enable0 = 1'b0; enable1 = 1'b0; mute0 = 1'b0; mute1 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_outs", {bclk0, pblrc0, pbdat0, mclk0, half0, bif0.BRAM_en}, 6'd0);
        chk("rst_rd_ptr", rd_ptr0, 3'd0);
        chk("rst_bram_rst", bif0.BRAM_rst, 1'b1);
        rstn = 1'b1;

        tog = 0; prev = mclk0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mclk0 !== prev) tog++;
            prev = mclk0;
        end
        chk("mclk_toggles", 128'(tog), 128'd20);
        chk("idle_no_read", 128'(addr_cnt), 128'd0);
        chk("bram_static", {bif0.BRAM_rst, bif0.BRAM_we, bif0.BRAM_din}, 37'd0);

        enable0 = 1'b1;
        cap(0, 64, d, lr, lat, per);
        chk("f1_data", d[63:0], i2s_exp(24'hABCDEF, 24'h123456));
        chk("f1_lrclk", lr[63:0], 64'h00000000_FFFFFFFF);
        chk("f1_latency_ok", (lat > 0) && (lat <= 10), 1'b1);
        chk("bclk_period", 128'(per), 128'd8);

        mute0 = 1'b1;
        cap(0, 64, d, lr, lat, per);
        chk("f2_muted", d[63:0], 64'd0);
        chk("f2_lrclk", lr[63:0], 64'h00000000_FFFFFFFF);
        mute0 = 1'b0;
        cap(0, 64, d, lr, lat, per);
        chk("f3_data", d[63:0], i2s_exp(24'h800001, 24'h000002));
        cap(0, 64, d, lr, lat, per);
        chk("f4_data", d[63:0], i2s_exp(24'hF0F0F0, 24'h0F0F0F));
        cap(0, 64, d, lr, lat, per);
        chk("f5_wrap_data", d[63:0], i2s_exp(24'hABCDEF, 24'h123456));
        for (int i = 0; i < 10; i++) chk($sformatf("addr_%0d", i), 128'(addr_log[i]), 128'((i % 8) * 4));
        chk("irq0_ptr", 128'(irq_log[0]), 128'd4);
        chk("irq1_ptr", 128'(irq_log[1]), 128'd0);

        cap(0, 20, d1, lr1, lat, per);
        enable0 = 1'b0;
        cap(0, 44, d, lr, lat, per);
        chk("f6_completes", {d1[19:0], d[43:0]}, i2s_exp(24'hFFFFFF, 24'h000001));
        repeat (10) @(negedge clk);
        chk("stop_outs", {bclk0, pblrc0, pbdat0}, 3'd0);
        chk("stop_rewind", rd_ptr0, 3'd4);
        rises = 0; prev = bclk0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bclk0 && !prev) rises++;
            prev = bclk0;
        end
        chk("stop_bclk_idle", 128'(rises), 128'd0);

        enable0 = 1'b1;
        cap(0, 64, d, lr, lat, per);
        chk("restart_data", d[63:0], i2s_exp(24'h800001, 24'h000002));
        chk("restart_latency_ok", (lat > 0) && (lat <= 10), 1'b1);
        chk("restart_addr", 128'(addr_log[14]), 128'd16);
        chk("read_count", 128'(addr_cnt), 128'd18);
        chk("irq_count", 128'(irq_cnt), 128'd4);
        chk("irq2_ptr", 128'(irq_log[2]), 128'd4);
        chk("no_read_disabled", 128'(en_dis0), 128'd0);

        cap(0, 37, d, lr, lat, per);
        rstn = 1'b0;
        #1;
        chk("midrst_outs", {bclk0, pblrc0, pbdat0, mclk0, half0, bif0.BRAM_en}, 6'd0);
        chk("midrst_rd_ptr", rd_ptr0, 3'd0);
        enable0 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        enable1 = 1'b1;
        cap(1, 128, d, lr, lat, per);
        chk("tdm_f1_data", d, tdm_exp(16'hAAAA, 16'hBBBB, 16'hC3C5, 16'h8001));
        chk("tdm_slot2", d[63:32], {1'b0, 16'hC3C5, 15'd0});
        chk("tdm_f1_lrclk", lr, {1'b1, 127'd0});
        chk("tdm_latency_ok", (lat > 0) && (lat <= 12), 1'b1);
        cap(1, 128, d, lr, lat, per);
        chk("tdm_f2_data", d, tdm_exp(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0));
        chk("tdm_f2_lrclk", lr, {1'b1, 127'd0});
        chk("tdm_no_read_disabled", 128'(en_dis1), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
